// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder reused LSB-first over WIDTH cycles,
// sequenced by a three-state IDLE/RUN/DONE controller.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_carry;
    logic             last_bit;

    assign fa_sum   = opa[0] ^ opb[0] ^ carry;
    assign fa_carry = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign res_nxt  = (res >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
    assign last_bit = (cnt == CW'(WIDTH - 1));

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= A;
                        opb   <= B;
                        carry <= Cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    res   <= res_nxt;
                    carry <= fa_carry;
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        Sum  <= res_nxt;
                        Cout <= fa_carry;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 1..32.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 Port: A  input  WIDTH  operand A; captured on accepted start.
REQ-006 Port: B  input  WIDTH  operand B; captured on accepted start.
REQ-007 Port: Cin  input  1  carry-in; captured on accepted start.
REQ-008 Port: busy  output  1  high while an addition is in progress (RUN state).
REQ-009 Port: done  output  1  one-cycle pulse: Sum/Cout just updated with a new result.
REQ-010 Port: Sum  output  WIDTH  registered result, A+B+Cin modulo 2^WIDTH.
REQ-011 Port: Cout  output  1  registered carry-out of the WIDTH-bit addition.

Function
REQ-012 Datapath SHALL be a single 1-bit full adder (sum = a^b^c, carry = ab|ac|bc) reused once per cycle, LSB first; no WIDTH-bit parallel adder.
REQ-013 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 IDLE: start=1 at an edge SHALL capture A, B into operand shift registers, Cin into the carry flop, clear bit counter to 0, go to RUN; start=0 stays IDLE.
REQ-015 RUN: each edge SHALL add operand LSBs with the carry flop, shift the sum bit into the result shift register from the MSB side, update the carry flop, shift operands right by one, increment the counter.
REQ-016 RUN SHALL last exactly WIDTH edges; on the edge processing bit WIDTH-1, go to DONE and load Sum with the completed result and Cout with the final carry.
REQ-017 DONE SHALL last exactly one cycle, then go to IDLE unconditionally.
REQ-018 Latency: with start captured at edge 0, done SHALL be high in the cycle following edge WIDTH, and low otherwise.
REQ-019 busy SHALL be high exactly in RUN (WIDTH cycles per operation); done SHALL be high exactly in DONE; busy and done never high together.
REQ-020 start while in RUN or DONE SHALL be ignored (not queued); the operation in progress is unaffected.
REQ-021 Changes on A, B, Cin after capture SHALL NOT affect the result in progress.
REQ-022 Sum and Cout SHALL change only on the edge entering DONE and hold their value through IDLE and the next RUN until the next completion.
REQ-023 WIDTH=1: one RUN cycle; Sum/Cout SHALL equal the full-adder truth table for (A,B,Cin).
REQ-024 Bit counter SHALL be sized ceil(log2(WIDTH+1)) bits and SHALL NOT wrap within an operation.
REQ-025 Back-to-back: start held high continuously SHALL yield one operation every WIDTH+2 cycles (RUN×WIDTH, DONE, IDLE).

Reset
REQ-026 rst_n=0 SHALL immediately, without a clock edge, force state IDLE, busy=0, done=0, Sum=0, Cout=0, counter, carry and shift registers to 0.
REQ-027 Reset asserted mid-RUN SHALL abandon the operation; no done pulse; Sum/Cout read 0.
REQ-028 After rst_n deasserts, the first start SHALL be accepted on the next rising edge at which it is sampled high.

Verification (WIDTH=8 unless stated)
REQ-029 A=0x3C, B=0x42, Cin=0, start 1 cycle -> busy high 8 cycles, done pulse after edge 8, Sum=0x7E, Cout=0.
REQ-030 A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1; A=0xA5, B=0x5A, Cin=1 -> Sum=0x00, Cout=1; A=0, B=0, Cin=0 -> Sum=0x00, Cout=0.
REQ-031 Start 0x10+0x20, pulse start again at RUN cycle 3 with A=0xFF, B=0xFF -> single done, Sum=0x30, Cout=0; Sum then holds 0x30 in IDLE.
REQ-032 Start 0xFF+0xFF+1, assert rst_n=0 at RUN cycle 4 -> busy, done, Sum, Cout go 0 asynchronously; no done pulse; next start 0x01+0x01+0 -> Sum=0x02.
REQ-033 WIDTH=1: all 8 (A,B,Cin) combinations 000..111 in order -> (Cout,Sum) = 00,01,01,10,01,10,10,11; done 1 cycle after each RUN cycle.
REQ-034 start held high 3 operations, A/B changed only during IDLE -> done pulses exactly 10 cycles apart, each result correct for operands captured at its start edge.
